// File: rtl/decode_instruction_pkg.sv
// Shared encodings for the instruction decode stage: op kinds, byte classes,
// prefix folding constants and the output-slot state type.
package decode_defs;

  localparam int DATA_BITS    = 16;
  localparam int PC_BITS      = 9;
  localparam int PREFIX_SHIFT = 6;
  localparam int PAYLOAD_BITS = 6;

  typedef enum logic [1:0] {
    OP_KIND_OP    = 2'd0,
    OP_KIND_PUSH  = 2'd1,
    OP_KIND_RSVD2 = 2'd2,
    OP_KIND_RSVD3 = 2'd3
  } opKind_t;

  // Class is decided by bits [7:6]; any byte with bit 7 clear is an OP.
  localparam logic [1:0] CLASS_PREFIX = 2'b10;
  localparam logic [1:0] CLASS_PUSH   = 2'b11;

  typedef enum logic [1:0] {
    BYTE_OP,
    BYTE_PREFIX,
    BYTE_PUSH
  } byteClass_t;

  typedef enum logic {
    SLOT_FREE,
    SLOT_FULL
  } slotState_t;

  function automatic byteClass_t classifyByte(input logic [7:0] b);
    if (!b[7])                   return BYTE_OP;
    else if (b[7:6] == CLASS_PUSH) return BYTE_PUSH;
    else                         return BYTE_PREFIX;
  endfunction

endpackage

// File: rtl/decode_instruction_if.sv
// Fetch-to-decode byte handshake and decode-to-execute op handshake.
// master = fetch/execute side, slave = decode stage.
interface decode_instruction_if #(
  parameter int dataBits = 16,
  parameter int pcBits   = 9
);
  logic                inValid;
  logic                inReady;
  logic [7:0]          instruction;
  logic [pcBits-1:0]   instructionPc;
  logic                outValid;
  logic                outReady;
  logic [1:0]          opKind;
  logic [6:0]          opcode;
  logic [dataBits-1:0] immediate;
  logic [pcBits-1:0]   opStartPc;
  logic [pcBits-1:0]   opNextPc;

  modport master (
    output inValid, instruction, instructionPc, outReady,
    input  inReady, outValid, opKind, opcode, immediate, opStartPc, opNextPc
  );

  modport slave (
    input  inValid, instruction, instructionPc, outReady,
    output inReady, outValid, opKind, opcode, immediate, opStartPc, opNextPc
  );
endinterface

// File: rtl/decode_instruction_prefix.sv
// prefix_accumulator: folds prefix payloads into the operand and remembers the
// PC of the first prefix. DECODE_PREFIX_OVERFLOW_EN adds a sticky overflow flag.
module prefix_accumulator
  import decode_defs::*;
#(
  parameter int dataBits = DATA_BITS,
  parameter int pcBits   = PC_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    loadPrefix,
  input  logic [PAYLOAD_BITS-1:0] payload,
  input  logic [pcBits-1:0]       pc,
  output logic [dataBits-1:0]     acc,
  output logic [dataBits-1:0]     operand,
  output logic [pcBits-1:0]       startPc,
  output logic                    isEmpty
`ifdef DECODE_PREFIX_OVERFLOW_EN
  ,
  output logic                    overflow
`endif
);

  logic [1:0] prefixCount;

  assign operand = acc | dataBits'(payload);
  assign isEmpty = (prefixCount == 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      prefixCount <= '0;
      startPc     <= '0;
    end else if (clear) begin
      acc         <= '0;
      prefixCount <= '0;
    end else if (loadPrefix) begin
      // Bits shifted past the top are dropped on purpose.
      acc <= operand << PREFIX_SHIFT;
      if (prefixCount != 2'd3) prefixCount <= prefixCount + 2'd1;
      if (isEmpty) startPc <= pc;
    end
  end

`ifdef DECODE_PREFIX_OVERFLOW_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 overflow <= 1'b0;
    else if (loadPrefix && prefixCount == 2'd2) overflow <= 1'b1;
  end
`endif

endmodule

// File: rtl/decode_instruction.sv
// Instruction decode stage: byte stream in, one decoded op per final byte out.
// Optional DECODE_PREFIX_OVERFLOW_EN exposes a sticky prefixOverflow flag.
//
// state     | meaning
// SLOT_FREE | no decoded op held, outValid=0
// SLOT_FULL | decoded op held for execute, outValid=1
module decode_instruction
  import decode_defs::*;
#(
  parameter int dataBits = DATA_BITS,
  parameter int pcBits   = PC_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  decode_instruction_if.slave bus
`ifdef DECODE_PREFIX_OVERFLOW_EN
  ,
  output logic prefixOverflow
`endif
);

  slotState_t          slotState, slotNext;
  byteClass_t          byteClass;
  logic                accept, loadPrefix, loadOp, clearAcc;
  logic [dataBits-1:0] acc, operand;
  logic [pcBits-1:0]   startPc;
  logic                isEmpty;

  opKind_t             opKindQ;
  logic [6:0]          opcodeQ;
  logic [dataBits-1:0] immediateQ;
  logic [pcBits-1:0]   opStartPcQ, opNextPcQ;

  assign byteClass   = classifyByte(bus.instruction);
  assign bus.outValid = (slotState == SLOT_FULL);
  assign bus.inReady  = !bus.outValid || bus.outReady;
  assign accept       = bus.inValid && bus.inReady && !flush;
  assign loadPrefix   = accept && (byteClass == BYTE_PREFIX);
  assign loadOp       = accept && (byteClass != BYTE_PREFIX);
  assign clearAcc     = flush || loadOp;

  prefix_accumulator #(
    .dataBits (dataBits),
    .pcBits   (pcBits)
  ) u_prefix (
    .clk        (clk),
    .reset      (reset),
    .clear      (clearAcc),
    .loadPrefix (loadPrefix),
    .payload    (bus.instruction[PAYLOAD_BITS-1:0]),
    .pc         (bus.instructionPc),
    .acc        (acc),
    .operand    (operand),
    .startPc    (startPc),
    .isEmpty    (isEmpty)
`ifdef DECODE_PREFIX_OVERFLOW_EN
    ,
    .overflow   (prefixOverflow)
`endif
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slotState <= SLOT_FREE;
    else        slotState <= slotNext;
  end

  // A load in the same cycle as a drain keeps the slot full with the new op.
  always_comb begin
    slotNext = slotState;
    if (flush)
      slotNext = SLOT_FREE;
    else if (loadOp)
      slotNext = SLOT_FULL;
    else if (slotState == SLOT_FULL && bus.outReady)
      slotNext = SLOT_FREE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opKindQ    <= OP_KIND_OP;
      opcodeQ    <= '0;
      immediateQ <= '0;
      opStartPcQ <= '0;
      opNextPcQ  <= '0;
    end else if (loadOp) begin
      opStartPcQ <= isEmpty ? bus.instructionPc : startPc;
      opNextPcQ  <= bus.instructionPc + 1'b1;
      if (byteClass == BYTE_PUSH) begin
        opKindQ    <= OP_KIND_PUSH;
        opcodeQ    <= '0;
        immediateQ <= operand;
      end else begin
        opKindQ    <= OP_KIND_OP;
        opcodeQ    <= bus.instruction[6:0];
        immediateQ <= acc;
      end
    end
  end

  assign bus.opKind    = opKindQ;
  assign bus.opcode    = opcodeQ;
  assign bus.immediate = immediateQ;
  assign bus.opStartPc = opStartPcQ;
  assign bus.opNextPc  = opNextPcQ;

endmodule
